// File: rtl/ped_signal_ctrl_if.sv
// Handshake bundle between the pedestrian signal controller, the push-button,
// the one-second timebase and the vehicle traffic controller.
interface ped_signal_ctrl_if;
    logic       pulse_1s;
    logic       button;
    logic       red_light;
    logic       pedestrian;
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;

    // Environment side: timebase, button and vehicle controller.
    modport master (
        output pulse_1s,
        output button,
        output red_light,
        input  pedestrian,
        input  walk,
        input  dont_walk,
        input  countdown
    );

    // Controller side.
    modport slave (
        input  pulse_1s,
        input  button,
        input  red_light,
        output pedestrian,
        output walk,
        output dont_walk,
        output countdown
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: requests a vehicle red, then runs a steady
// WALK phase and a flashing DONT_WALK clearance countdown.
module ped_signal_ctrl #(
    parameter int unsigned WALK_TIME  = 5,  // 1..15 pulse_1s periods
    parameter int unsigned CLEAR_TIME = 4   // 1..15 pulse_1s periods
) (
    input  logic          clk,
    input  logic          rst,
    ped_signal_ctrl_if.slave bus
);

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_TIME);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_TIME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WALK  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] counter;
    logic       pending;
    logic       flash;

    logic       btn_meta;
    logic       btn_sync;
    logic       btn_prev;
    logic [1:0] btn_settle;
    logic       red_prev;
    logic       red_valid;

    logic       pedestrian_q;
    logic       walk_q;
    logic       dont_walk_q;
    logic [3:0] countdown_q;

    logic       press;
    logic       red_rise;
    logic       last_second;

    // Presses are masked until the synchronizer has filled after reset, so a
    // button held through reset must be released and pressed again.
    assign press       = btn_sync & ~btn_prev & (btn_settle == 2'd0);
    assign red_rise    = bus.red_light & ~red_prev & red_valid;
    assign last_second = bus.pulse_1s & (counter == 4'd1);

    // NOTE: every register below is updated with non-blocking assignments so
    // all flops sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= 4'd0;
            pending      <= 1'b0;
            flash        <= 1'b0;
            btn_meta     <= 1'b0;
            btn_sync     <= 1'b0;
            btn_prev     <= 1'b0;
            btn_settle   <= 2'd3;
            red_prev     <= 1'b0;
            red_valid    <= 1'b0;
            pedestrian_q <= 1'b0;
            walk_q       <= 1'b0;
            dont_walk_q  <= 1'b1;
            countdown_q  <= 4'd0;
        end else begin
            btn_meta  <= bus.button;
            btn_sync  <= btn_meta;
            btn_prev  <= btn_sync;
            red_prev  <= bus.red_light;
            red_valid <= 1'b1;
            if (btn_settle != 2'd0) begin
                btn_settle <= btn_settle - 2'd1;
            end

            unique case (state)
                IDLE: begin
                    if (press || pending) begin
                        state        <= WAIT;
                        pending      <= 1'b0;
                        pedestrian_q <= 1'b1;
                    end
                    walk_q      <= 1'b0;
                    dont_walk_q <= 1'b1;
                    countdown_q <= 4'd0;
                end

                WAIT: begin
                    // Only a fresh red edge starts WALK; a red already showing
                    // may be about to end.
                    if (red_rise) begin
                        state        <= WALK;
                        counter      <= WALK_LOAD;
                        pedestrian_q <= 1'b0;
                        walk_q       <= 1'b1;
                        dont_walk_q  <= 1'b0;
                    end
                end

                WALK: begin
                    if (press) begin
                        pending <= 1'b1;
                    end
                    if (!bus.red_light) begin
                        state       <= IDLE;
                        counter     <= 4'd0;
                        flash       <= 1'b0;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= 4'd0;
                    end else if (last_second) begin
                        state       <= CLEAR;
                        counter     <= CLEAR_LOAD;
                        flash       <= 1'b1;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= CLEAR_LOAD;
                    end else if (bus.pulse_1s) begin
                        counter <= counter - 4'd1;
                    end
                end

                CLEAR: begin
                    if (press) begin
                        pending <= 1'b1;
                    end
                    if (!bus.red_light || last_second) begin
                        state       <= IDLE;
                        counter     <= 4'd0;
                        flash       <= 1'b0;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= 4'd0;
                    end else if (bus.pulse_1s) begin
                        counter     <= counter - 4'd1;
                        flash       <= ~flash;
                        dont_walk_q <= ~flash;
                        countdown_q <= counter - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pedestrian = pedestrian_q;
    assign bus.walk       = walk_q;
    assign bus.dont_walk  = dont_walk_q;
    assign bus.countdown  = countdown_q;

endmodule

// File: doc/ped_signal_ctrl.md
PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 5, duration of the steady WALK phase in pulse_1s periods; legal range 1..15.
REQ-002 Parameter CLEAR_TIME, default 4, duration of the flashing DONT_WALK clearance phase in pulse_1s periods; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pulse_1s  input  1  one-clk-wide strobe once per second.
REQ-006 button  input  1  raw, asynchronous pedestrian push-button, high while pressed.
REQ-007 red_light  input  1  vehicle red indication from the vehicle traffic controller.
REQ-008 pedestrian  output  1  registered request to the vehicle traffic controller; high while a request is pending.
REQ-009 walk  output  1  registered steady WALK lamp.
REQ-010 dont_walk  output  1  registered DONT_WALK lamp; steady or flashing per state.
REQ-011 countdown  output  4  registered clearance seconds remaining; 0 outside CLEAR.

Function
REQ-012 button shall pass through a 2-flop synchronizer; a press is the synchronized 0->1 edge, giving 3-clk latency from a raw edge to detection.
REQ-013 The red start shall be detected as a red_light 0->1 edge using a registered copy of red_light (red_rise).
REQ-014 States: IDLE, WAIT, WALK, CLEAR (2-bit encoded).
REQ-015 IDLE: walk=0, dont_walk=1 steady, pedestrian=0; press or pending flag set -> WAIT next clk.
REQ-016 WAIT: pedestrian=1, dont_walk=1 steady; red_rise -> WALK, loading the second counter with WALK_TIME.
REQ-017 In WAIT, red_light already high without a red_rise shall not start WALK; wait for the next red_rise.
REQ-018 WALK: walk=1, dont_walk=0, pedestrian=0; each pulse_1s decrements the counter; pulse_1s with counter==1 -> CLEAR, loading CLEAR_TIME and setting flash phase=1.
REQ-019 CLEAR: walk=0, dont_walk=flash phase, countdown=counter; each pulse_1s decrements the counter and toggles the flash phase; pulse_1s with counter==1 -> IDLE.
REQ-020 Safety abort: red_light==0 while in WALK or CLEAR -> IDLE next clk, overriding all other transitions; walk=0, dont_walk=1 steady, countdown=0 in that cycle.
REQ-021 A press detected in WALK or CLEAR shall set a 1-bit pending flag.
REQ-022 The pending flag shall clear on entry to WAIT.
REQ-023 Repeated presses in WAIT shall have no effect.
REQ-024 pulse_1s coincident with a state-entry clk shall not count toward the new state's duration.
REQ-025 The counter shall never decrement below 1 or wrap.
REQ-026 All outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 On rst=1 at a clk edge, the block shall be in: state IDLE, pedestrian=0, walk=0, dont_walk=1, countdown=0, counter=0, pending=0, flash phase=0, synchronizer flops=0, red_light history=0.
REQ-028 rst asserted mid-WALK or mid-CLEAR shall abandon the crossing with no partial countdown.
REQ-029 After reset the block shall ignore a button held high until it is released and pressed again.
REQ-030 After reset a red_light already high shall not produce a red_rise.

Verification
REQ-031 Press button for 2 clk in IDLE, red_light 0->1 20 clk later -> pedestrian=1 by clk 4 after press; walk=1 one clk after red_rise; pedestrian=0 in the same cycle.
REQ-032 Defaults, red held high, pulse_1s every 10 clk -> walk high for exactly 5 pulses; then countdown shows 4,3,2,1 with dont_walk toggling 1,0,1,0; then IDLE with countdown=0 and dont_walk=1.
REQ-033 Drop red_light during WALK after 2 pulses -> next clk: walk=0, dont_walk=1, countdown=0, state IDLE.
REQ-034 Press during CLEAR -> pending set; on CLEAR->IDLE, WAIT one clk later with pedestrian=1.
REQ-035 In WAIT with red_light already high -> no WALK until red_light falls and rises again.
REQ-036 Assert rst with countdown=3 -> next clk all outputs at REQ-027 values; a button held through reset does not raise pedestrian.
